// File: rtl/rw_request_scheduler_pkg.sv
// Shared types for the read/write request scheduler: frontend command format,
// scheduler state encoding and transfer direction.
package rw_request_scheduler_pkg;

    typedef struct packed {
        logic [7:0]  id;
        logic [23:0] addr;
    } frontend_command_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_TURN  = 2'd3
    } sched_state_e;

    typedef enum logic {
        DIR_READ  = 1'b0,
        DIR_WRITE = 1'b1
    } dir_e;

    localparam int TURN_CNT_W   = 4;
    localparam int STARVE_CNT_W = 8;

    function automatic sched_state_e dir_state(input dir_e d);
        return (d == DIR_WRITE) ? ST_WRITE : ST_READ;
    endfunction

endpackage

// File: rtl/rw_request_scheduler_if.sv
// FIFO-side and backend-side handshake bundle of the read/write scheduler.
// master = scheduler side, slave = FIFOs/backend side.
interface rw_request_scheduler_if;
    import rw_request_scheduler_pkg::*;

    logic              rd_empty;
    frontend_command_t rd_data;
    logic              rd_pop;
    logic              wr_empty;
    frontend_command_t wr_data;
    logic              wr_pop;
    logic              wr_flush;
    logic              cmd_valid;
    logic              cmd_ready;
    frontend_command_t cmd_out;
    logic              cmd_is_write;
    logic [1:0]        sched_state;

    modport master (
        input  rd_empty, rd_data, wr_empty, wr_data, wr_flush, cmd_ready,
        output rd_pop, wr_pop, cmd_valid, cmd_out, cmd_is_write, sched_state
    );

    modport slave (
        output rd_empty, rd_data, wr_empty, wr_data, wr_flush, cmd_ready,
        input  rd_pop, wr_pop, cmd_valid, cmd_out, cmd_is_write, sched_state
    );

endinterface

// File: rtl/rw_turnaround_timer.sv
// Turnaround down-counter: loaded with the turn length on start, done when the
// remaining count reaches zero (done holds on the last turn cycle).
module rw_turnaround_timer
    import rw_request_scheduler_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  done,
    input  logic [TURN_CNT_W-1:0] count
);

    logic [TURN_CNT_W-1:0] remain_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remain_q <= '0;
        end else if (start) begin
            remain_q <= (count == '0) ? '0 : count - 1'b1;
        end else if (remain_q != '0) begin
            remain_q <= remain_q - 1'b1;
        end
    end

    assign done = (remain_q == '0);

endmodule

// File: rtl/rw_request_scheduler.sv
// Read/write request scheduler with single-register output slot and bus turnaround.
// Optional starvation guard on reads when RW_STARVE_GUARD_EN is defined.
//
// state | meaning
// IDLE  | nothing wanted; output slot drains
// READ  | loading commands from the read FIFO
// WRITE | loading commands from the write FIFO
// TURN  | direction change gap, no loads; target latched on entry
module rw_request_scheduler
    import rw_request_scheduler_pkg::*;
#(
    parameter int unsigned TURN_CYCLES  = 2,
    parameter int unsigned STARVE_LIMIT = 8
)
(
    input  logic                  clk,
    input  logic                  rst,
    rw_request_scheduler_if.master bus
);

    localparam logic [TURN_CNT_W-1:0] TURN_LEN  = TURN_CNT_W'(TURN_CYCLES);
    localparam bit                    SKIP_TURN = (TURN_CYCLES == 0);

    sched_state_e      state_q, state_d;
    dir_e              last_dir_q, turn_target_q, want_dir;
    logic              want_write, want_read, want_any;
    logic              slot_free, rd_load, wr_load;
    logic              turn_start, turn_done, starve_trip;
    logic              cmd_valid_q, cmd_is_write_q;
    frontend_command_t cmd_out_q;

    assign slot_free = !cmd_valid_q || bus.cmd_ready;

    // Write is only ever wanted with something to write, so a flush on an empty FIFO cannot stall.
    assign want_write = !bus.wr_empty && (bus.wr_flush || starve_trip || bus.rd_empty);
    assign want_read  = !want_write && !bus.rd_empty;
    assign want_any   = want_write || want_read;
    assign want_dir   = want_write ? DIR_WRITE : DIR_READ;

    always_comb begin
        state_d    = state_q;
        turn_start = 1'b0;
        rd_load    = 1'b0;
        wr_load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (want_any) begin
                    if (want_dir == last_dir_q || SKIP_TURN) begin
                        state_d = dir_state(want_dir);
                    end else begin
                        state_d    = ST_TURN;
                        turn_start = 1'b1;
                    end
                end
            end
            ST_READ, ST_WRITE: begin
                if (slot_free) begin
                    if (!want_any) begin
                        state_d = ST_IDLE;
                    end else if (dir_state(want_dir) == state_q) begin
                        rd_load = (state_q == ST_READ);
                        wr_load = (state_q == ST_WRITE);
                    end else if (SKIP_TURN) begin
                        state_d = dir_state(want_dir);
                    end else begin
                        state_d    = ST_TURN;
                        turn_start = 1'b1;
                    end
                end
            end
            ST_TURN: begin
                if (turn_done) begin
                    state_d = dir_state(turn_target_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dir_q    <= DIR_READ;
            turn_target_q <= DIR_READ;
        end else begin
            if (rd_load) last_dir_q <= DIR_READ;
            if (wr_load) last_dir_q <= DIR_WRITE;
            if (turn_start) turn_target_q <= want_dir;
        end
    end

    rw_turnaround_timer u_turn_timer (
        .clk   (clk),
        .rst   (rst),
        .start (turn_start),
        .done  (turn_done),
        .count (TURN_LEN)
    );

`ifdef RW_STARVE_GUARD_EN
    logic [STARVE_CNT_W-1:0] starve_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else if (wr_load || bus.wr_empty) begin
            starve_cnt_q <= '0;
        end else if (rd_load) begin
            starve_cnt_q <= starve_cnt_q + 1'b1;
        end
    end

    assign starve_trip = (starve_cnt_q == STARVE_CNT_W'(STARVE_LIMIT));
`else
    // Legal limits start at 1, so this is constantly low without the guard.
    assign starve_trip = (STARVE_LIMIT == 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid_q    <= 1'b0;
            cmd_out_q      <= '0;
            cmd_is_write_q <= 1'b0;
        end else if (rd_load) begin
            cmd_valid_q    <= 1'b1;
            cmd_out_q      <= bus.rd_data;
            cmd_is_write_q <= 1'b0;
        end else if (wr_load) begin
            cmd_valid_q    <= 1'b1;
            cmd_out_q      <= bus.wr_data;
            cmd_is_write_q <= 1'b1;
        end else if (bus.cmd_ready) begin
            cmd_valid_q <= 1'b0;
        end
    end

    assign bus.rd_pop       = rd_load;
    assign bus.wr_pop       = wr_load;
    assign bus.cmd_valid    = cmd_valid_q;
    assign bus.cmd_out      = cmd_out_q;
    assign bus.cmd_is_write = cmd_is_write_q;
    assign bus.sched_state  = state_q;

endmodule

// File: tb/tb_rw_request_scheduler.sv
// Directed bench for rw_request_scheduler (TURN_CYCLES=2, STARVE_LIMIT=4); the
// bench itself models both request FIFOs as show-ahead queues.
module tb_rw_request_scheduler;
    import rw_request_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rw_request_scheduler_if bus();

    rw_request_scheduler #(.TURN_CYCLES(2), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    frontend_command_t rd_mem [32];
    frontend_command_t wr_mem [32];
    int rd_head = 0, rd_tail = 0, wr_head = 0, wr_tail = 0;
    int errors = 0, checks = 0;

    function automatic frontend_command_t rcmd(input int i);
        frontend_command_t c;
        c.id   = 8'(16 + i);
        c.addr = 24'(256 + 4 * i);
        return c;
    endfunction

    function automatic frontend_command_t wcmd(input int i);
        frontend_command_t c;
        c.id   = 8'(128 + i);
        c.addr = 24'(32768 + 4 * i);
        return c;
    endfunction

    task automatic drive_fifo();
        bus.rd_empty = (rd_head == rd_tail);
        bus.rd_data  = (rd_head < rd_tail) ? rd_mem[rd_head] : '0;
        bus.wr_empty = (wr_head == wr_tail);
        bus.wr_data  = (wr_head < wr_tail) ? wr_mem[wr_head] : '0;
    endtask

    task automatic push_rd(input int n);
        for (int i = 0; i < n; i++) begin
            rd_mem[rd_tail] = rcmd(rd_tail);
            rd_tail++;
        end
        drive_fifo();
    endtask

    task automatic push_wr(input int n);
        for (int i = 0; i < n; i++) begin
            wr_mem[wr_tail] = wcmd(wr_tail);
            wr_tail++;
        end
        drive_fifo();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; pops seen mid-cycle are applied to the FIFO model after the edge.
    task automatic tick();
        logic rp, wp;
        rp = bus.rd_pop;
        wp = bus.wr_pop;
        chk("pop_rules", {29'd0, rp & wp, rp & bus.rd_empty, wp & bus.wr_empty}, 32'd0);
        @(posedge clk);
        #1;
        if (rp) rd_head++;
        if (wp) wr_head++;
        drive_fifo();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, wb;
        logic [4:0]  a_pop, a_valid;
        logic [9:0]  a_state;
        logic [11:0] d_rd, d_wr;
        logic [23:0] d_st;
        int          d_wr_out;

        bus.cmd_ready = 1'b1;
        bus.wr_flush  = 1'b0;
        push_rd(2);
        push_wr(2);
        #1 rst = 1'b1;
        #1;

        // reset with both FIFOs non-empty
        chk("rst.valid", bus.cmd_valid, 0);
        chk("rst.out", bus.cmd_out, 0);
        chk("rst.is_write", bus.cmd_is_write, 0);
        chk("rst.rd_pop", bus.rd_pop, 0);
        chk("rst.wr_pop", bus.wr_pop, 0);
        chk("rst.state", bus.sched_state, 0);
        tick();
        tick();
        chk("rst.valid_held", bus.cmd_valid, 0);
        chk("rst.pops_held", {bus.rd_pop, bus.wr_pop}, 0);
        chk("rst.state_held", bus.sched_state, 0);
        rd_head = rd_tail;
        wr_head = wr_tail;
        drive_fifo();
        rst = 1'b0;
        #1;
        chk("rel.state", bus.sched_state, 0);

        // three reads, backend always ready
        push_rd(3);
        base = rd_head;
        #1;
        chk("A.state0", bus.sched_state, 0);
        chk("A.pop0", bus.rd_pop, 0);
        a_pop   = 5'b00111;
        a_valid = 5'b01110;
        a_state = 10'b00_01_01_01_01;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("A.rd_pop c%0d", c), bus.rd_pop, a_pop[c-1]);
            chk($sformatf("A.valid c%0d", c), bus.cmd_valid, a_valid[c-1]);
            chk($sformatf("A.state c%0d", c), bus.sched_state, a_state[2*(c-1) +: 2]);
            if (a_valid[c-1]) begin
                chk($sformatf("A.out c%0d", c), bus.cmd_out, rcmd(base + c - 2));
                chk($sformatf("A.is_write c%0d", c), bus.cmd_is_write, 0);
            end
        end

        // backpressure for five cycles
        push_rd(2);
        base = rd_head;
        bus.cmd_ready = 1'b0;
        #1;
        tick();
        chk("B.state c1", bus.sched_state, 1);
        chk("B.rd_pop c1", bus.rd_pop, 1);
        chk("B.valid c1", bus.cmd_valid, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("B.hold_out c%0d", k + 2), bus.cmd_out, rcmd(base));
            chk($sformatf("B.hold_valid c%0d", k + 2), bus.cmd_valid, 1);
            chk($sformatf("B.no_pop c%0d", k + 2), bus.rd_pop, 0);
        end
        tick();
        bus.cmd_ready = 1'b1;
        #1;
        chk("B.pop_after_ready", bus.rd_pop, 1);
        tick();
        chk("B.out2", bus.cmd_out, rcmd(base + 1));
        chk("B.valid2", bus.cmd_valid, 1);
        chk("B.rd_pop_done", bus.rd_pop, 0);
        tick();
        chk("B.valid_clear", bus.cmd_valid, 0);
        chk("B.state_idle", bus.sched_state, 0);
        chk("B.pop_count", rd_head, base + 2);

        // write flush rises during READ
        push_rd(4);
        push_wr(2);
        base = rd_head;
        wb   = wr_head;
        #1;
        tick();
        chk("C.state c1", bus.sched_state, 1);
        chk("C.rd_pop c1", bus.rd_pop, 1);
        tick();
        bus.wr_flush = 1'b1;
        #1;
        chk("C.state c2", bus.sched_state, 1);
        chk("C.no_read_on_flush", bus.rd_pop, 0);
        chk("C.out c2", bus.cmd_out, rcmd(base));
        tick();
        chk("C.turn c3", bus.sched_state, 3);
        chk("C.turn_pops c3", {bus.rd_pop, bus.wr_pop}, 0);
        tick();
        chk("C.turn c4", bus.sched_state, 3);
        tick();
        chk("C.state c5", bus.sched_state, 2);
        chk("C.wr_pop c5", bus.wr_pop, 1);
        tick();
        chk("C.state c6", bus.sched_state, 2);
        chk("C.wr_pop c6", bus.wr_pop, 1);
        chk("C.out c6", bus.cmd_out, wcmd(wb));
        chk("C.is_write c6", bus.cmd_is_write, 1);
        tick();
        bus.wr_flush = 1'b0;
        #1;
        chk("C.state c7", bus.sched_state, 2);
        chk("C.out c7", bus.cmd_out, wcmd(wb + 1));
        chk("C.pops c7", {bus.rd_pop, bus.wr_pop}, 0);
        tick();
        chk("C.turn c8", bus.sched_state, 3);
        tick();
        chk("C.turn c9", bus.sched_state, 3);
        tick();
        chk("C.state c10", bus.sched_state, 1);
        chk("C.rd_pop c10", bus.rd_pop, 1);
        tick();
        chk("C.out c11", bus.cmd_out, rcmd(base + 1));
        chk("C.is_write c11", bus.cmd_is_write, 0);
        tick();
        tick();
        tick();
        chk("C.idle c14", bus.sched_state, 0);
        chk("C.valid c14", bus.cmd_valid, 0);
        chk("C.rd_drained", rd_head, rd_tail);

        // reads and writes both pending, no flush
        push_rd(6);
        push_wr(2);
        wb = wr_head;
        #1;
`ifdef RW_STARVE_GUARD_EN
        d_rd     = 12'b1000_0000_1111;
        d_wr     = 12'b0000_1000_0000;
        d_st     = 24'b01_11_11_10_10_11_11_01_01_01_01_01;
        d_wr_out = 9;
`else
        d_rd     = 12'b0000_0011_1111;
        d_wr     = 12'b0110_0000_0000;
        d_st     = 24'b10_10_10_11_11_01_01_01_01_01_01_01;
        d_wr_out = 11;
`endif
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("D.rd_pop c%0d", c), bus.rd_pop, d_rd[c-1]);
            chk($sformatf("D.wr_pop c%0d", c), bus.wr_pop, d_wr[c-1]);
            chk($sformatf("D.state c%0d", c), bus.sched_state, d_st[2*(c-1) +: 2]);
            if (c == d_wr_out) begin
                chk("D.wr_out", bus.cmd_out, wcmd(wb));
                chk("D.wr_is_write", bus.cmd_is_write, 1);
            end
        end
        for (int k = 0; k < 20; k++) begin
            if (bus.sched_state == 2'd0 && !bus.cmd_valid && bus.rd_empty && bus.wr_empty) break;
            tick();
        end
        chk("D.drain_state", bus.sched_state, 0);
        chk("D.drain_rd", rd_head, rd_tail);
        chk("D.drain_wr", wr_head, wr_tail);

        // reset together with acceptance of a pending command
        push_rd(2);
        base = rd_head;
        bus.cmd_ready = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            if (bus.cmd_valid) break;
            tick();
        end
        chk("E.loaded_valid", bus.cmd_valid, 1);
        chk("E.loaded_out", bus.cmd_out, rcmd(base));
        chk("E.blocked_pop", bus.rd_pop, 0);
        rst = 1'b1;
        bus.cmd_ready = 1'b1;
        #1;
        chk("E.valid", bus.cmd_valid, 0);
        chk("E.out", bus.cmd_out, 0);
        chk("E.is_write", bus.cmd_is_write, 0);
        chk("E.pops", {bus.rd_pop, bus.wr_pop}, 0);
        chk("E.state", bus.sched_state, 0);
        tick();
        chk("E.no_pop_in_reset", rd_head, base + 1);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 10; k++) begin
            if (bus.cmd_valid) break;
            tick();
        end
        chk("E.next_out", bus.cmd_out, rcmd(base + 1));
        chk("E.next_valid", bus.cmd_valid, 1);
        chk("E.rd_drained", rd_head, rd_tail);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
